// File: rtl/eny_sched_pkg.sv
// Shared definitions for the enemy-tank scheduler and the tank instances.
//   - sched_state_e : scheduler FSM encoding (IDLE/RUN/DRAIN/DONE)
//   - slot_idx_t    : 2-bit enemy slot index
//   - NUM_SLOTS     : number of enemy-tank slots
//   - corner_x/y    : spawn corner of each slot (slot i spawns at corner i)
//   - lowest_free_onehot : one-hot of the lowest-index slot whose alive bit is 0
package eny_sched_pkg;

  localparam int NUM_SLOTS = 4;

  typedef logic [1:0] slot_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // Playfield corners in tank-grid units: left/right column, top/bottom row.
  localparam logic [4:0] CORNER_X_LEFT   = 5'd0;
  localparam logic [4:0] CORNER_X_RIGHT  = 5'd16;
  localparam logic [4:0] CORNER_Y_TOP    = 5'd0;
  localparam logic [4:0] CORNER_Y_BOTTOM = 5'd20;

  // Bit 0 of the slot index selects the column, bit 1 the row.
  function automatic logic [4:0] corner_x(input slot_idx_t s);
    return s[0] ? CORNER_X_RIGHT : CORNER_X_LEFT;
  endfunction

  function automatic logic [4:0] corner_y(input slot_idx_t s);
    return s[1] ? CORNER_Y_BOTTOM : CORNER_Y_TOP;
  endfunction

  function automatic logic [3:0] lowest_free_onehot(input logic [3:0] alive);
    logic [3:0] r;
    if (!alive[0]) begin
      r = 4'b0001;
    end else if (!alive[1]) begin
      r = 4'b0010;
    end else if (!alive[2]) begin
      r = 4'b0100;
    end else if (!alive[3]) begin
      r = 4'b1000;
    end else begin
      r = 4'b0000;
    end
    return r;
  endfunction

endpackage

// File: rtl/enytank_sched_rr_arbiter4.sv
// rr_arbiter4: 4-way round-robin arbiter with an internal rotating pointer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   en         : arbitration enable; pointer only moves on an enabled grant
//   req[3:0]   : request vector
//   gnt[3:0]   : combinational one-hot grant (zero when en=0 or no request)
//   valid      : a grant is being issued this cycle
// The search starts at the pointer; after a grant the pointer moves to
// granted+1 (mod 4) so the winner becomes lowest priority.
module rr_arbiter4
  import eny_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       valid
);

  slot_idx_t  rr_ptr_r;
  slot_idx_t  cand_s;
  slot_idx_t  pick_s;
  logic       found_s;
  logic [3:0] pick_oh_s;

  // Scan the four slots starting at the pointer; first requester wins.
  always_comb begin
    found_s   = 1'b0;
    pick_s    = 2'd0;
    pick_oh_s = 4'b0000;
    cand_s    = 2'd0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      cand_s = rr_ptr_r + slot_idx_t'(k);
      if (!found_s && req[cand_s]) begin
        found_s   = 1'b1;
        pick_s    = cand_s;
        pick_oh_s = 4'b0001 << cand_s;
      end else begin
        found_s   = found_s;
      end
    end
  end

  assign gnt   = en ? pick_oh_s : 4'b0000;
  assign valid = en & found_s;

  // Rotate the pointer past the slot that just won.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= 2'd0;
    end else if (en && found_s) begin
      rr_ptr_r <= pick_s + 2'd1;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

endmodule

// File: rtl/enytank_sched.sv
// enytank_sched: central scheduler for the four enemy-tank slots.
// Paces spawns with a tick-based gap counter, enforces the per-level enemy
// quota, round-robin arbitrates the shared enemy-bullet launcher and flags
// level cleared.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   pause        : (only with ENYTANK_SCHED_PAUSE_EN) freeze counters, spawns,
//                  grants and FSM; game_over still aborts
//   tick         : 4 Hz one-clk pulse, game-rate time base
//   game_start   : one-clk pulse, starts a level (from IDLE or DONE)
//   game_over    : level; aborts to IDLE, has priority over game_start
//   slot_alive   : per-slot tank alive feedback
//   fire_req     : per-slot fire request level
//   bul_busy     : shared enemy bullet in flight
//   tank_en      : per-slot spawn request, held until slot_alive acknowledges
//   fire_gnt     : one-hot, one-clk fire grant pulse
//   remaining    : enemies not yet spawned this level
//   level_clear  : all enemies spawned and destroyed
//   sched_state  : FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
// Optional feature macro: ENYTANK_SCHED_PAUSE_EN (adds the pause input).
module enytank_sched
  import eny_sched_pkg::*;
#(
  parameter int TOTAL_ENEMIES = 20,
  parameter int SPAWN_GAP     = 8,
  parameter int FIRE_TMO      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef ENYTANK_SCHED_PAUSE_EN
  input  logic       pause,
`endif
  input  logic       tick,
  input  logic       game_start,
  input  logic       game_over,
  input  logic [3:0] slot_alive,
  input  logic [3:0] fire_req,
  input  logic       bul_busy,
  output logic [3:0] tank_en,
  output logic [3:0] fire_gnt,
  output logic [4:0] remaining,
  output logic       level_clear,
  output logic [1:0] sched_state
);

  localparam logic [4:0] TOTAL_L    = 5'(TOTAL_ENEMIES);
  localparam logic [3:0] SPAWN_GAP_L = 4'(SPAWN_GAP);
  localparam logic [3:0] FIRE_TMO_L  = 4'(FIRE_TMO);

  sched_state_e state_r;
  logic [4:0]   remaining_r;
  logic [3:0]   gap_cnt_r;
  logic [3:0]   tank_en_r;
  logic [3:0]   fire_gnt_r;
  logic         fire_lock_r;
  logic         busy_seen_r;
  logic [3:0]   tmo_cnt_r;
  logic         level_clear_r;

  logic         pause_s;
  logic         tick_s;
  logic         start_s;
  logic [3:0]   spawn_pick_s;
  logic         spawn_ok_s;
  logic         arb_en_s;
  logic [3:0]   arb_req_s;
  logic [3:0]   arb_gnt_s;
  logic         arb_valid_s;

`ifdef ENYTANK_SCHED_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  // Qualified events and the spawn / grant eligibility conditions.
  always_comb begin
    tick_s       = tick & ~pause_s;
    start_s      = game_start & ~pause_s;
    spawn_pick_s = lowest_free_onehot(slot_alive);
    spawn_ok_s   = !pause_s && (gap_cnt_r == 4'd0) && (tank_en_r == 4'b0000) &&
                   (remaining_r != 5'd0) && (spawn_pick_s != 4'b0000);
    arb_req_s    = fire_req & slot_alive;
    arb_en_s     = !game_over && !pause_s && !fire_lock_r && !bul_busy &&
                   ((state_r == ST_RUN) || (state_r == ST_DRAIN));
  end

  rr_arbiter4 u_fire_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en_s),
    .req   (arb_req_s),
    .gnt   (arb_gnt_s),
    .valid (arb_valid_s)
  );

  // Scheduler FSM, spawn handshake and fire-lock tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      remaining_r   <= 5'd0;
      gap_cnt_r     <= 4'd0;
      tank_en_r     <= 4'b0000;
      fire_gnt_r    <= 4'b0000;
      fire_lock_r   <= 1'b0;
      busy_seen_r   <= 1'b0;
      tmo_cnt_r     <= 4'd0;
      level_clear_r <= 1'b0;
    end else if (game_over) begin
      // Abort; remaining is kept so the display still shows it.
      state_r       <= ST_IDLE;
      tank_en_r     <= 4'b0000;
      fire_gnt_r    <= 4'b0000;
      fire_lock_r   <= 1'b0;
      busy_seen_r   <= 1'b0;
      tmo_cnt_r     <= 4'd0;
      level_clear_r <= 1'b0;
    end else begin
      fire_gnt_r <= arb_gnt_s;

      // Lock is released by bul_busy falling after it was seen high, or by
      // the tick timeout if the bullet never launched.
      if (arb_valid_s) begin
        fire_lock_r <= 1'b1;
        busy_seen_r <= 1'b0;
        tmo_cnt_r   <= FIRE_TMO_L;
      end else if (fire_lock_r) begin
        if (bul_busy) begin
          busy_seen_r <= 1'b1;
        end else if (busy_seen_r) begin
          fire_lock_r <= 1'b0;
          busy_seen_r <= 1'b0;
        end else if (tick_s) begin
          if (tmo_cnt_r <= 4'd1) begin
            fire_lock_r <= 1'b0;
            tmo_cnt_r   <= 4'd0;
          end else begin
            tmo_cnt_r   <= tmo_cnt_r - 4'd1;
          end
        end else begin
          tmo_cnt_r <= tmo_cnt_r;
        end
      end else begin
        busy_seen_r <= 1'b0;
      end

      // Spawn request drops once the requested slot reports alive; a slot
      // that never comes alive keeps its request (no retry elsewhere).
      if ((tank_en_r & slot_alive) != 4'b0000) begin
        tank_en_r <= 4'b0000;
      end else begin
        tank_en_r <= tank_en_r;
      end

      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_s) begin
            state_r       <= ST_RUN;
            remaining_r   <= TOTAL_L;
            gap_cnt_r     <= 4'd0;
            level_clear_r <= 1'b0;
          end else begin
            state_r       <= state_r;
          end
        end
        ST_RUN: begin
          if (pause_s) begin
            state_r <= state_r;
          end else if ((remaining_r == 5'd0) && (tank_en_r == 4'b0000)) begin
            state_r <= ST_DRAIN;
          end else if (spawn_ok_s) begin
            tank_en_r   <= spawn_pick_s;
            remaining_r <= remaining_r - 5'd1;
            gap_cnt_r   <= SPAWN_GAP_L;
          end else if (tick_s && (gap_cnt_r != 4'd0)) begin
            gap_cnt_r   <= gap_cnt_r - 4'd1;
          end else begin
            gap_cnt_r   <= gap_cnt_r;
          end
        end
        ST_DRAIN: begin
          if (!pause_s && (slot_alive == 4'b0000)) begin
            state_r       <= ST_DONE;
            level_clear_r <= 1'b1;
          end else begin
            state_r       <= state_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign tank_en     = tank_en_r;
  assign fire_gnt    = fire_gnt_r;
  assign remaining   = remaining_r;
  assign level_clear = level_clear_r;
  assign sched_state = state_r;

endmodule

// File: tb/tb_enytank_sched.sv
// Scoreboard bench for enytank_sched. Stimulus pushes expected grants, spawns
// and state changes into queues; a negedge monitor pops and compares whenever
// the DUTs present them. u_dut runs the default 20-enemy level, u_dut2 a
// 2-enemy level for the DRAIN/DONE path.
module tb_enytank_sched;
  import eny_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, tick;
  logic       game_start, game_over, bul_busy;
  logic [3:0] slot_alive, fire_req;
  logic [3:0] tank_en, fire_gnt;
  logic [4:0] remaining;
  logic       level_clear;
  logic [1:0] sched_state;

  logic       game_start2, game_over2, bul_busy2;
  logic [3:0] slot_alive2, fire_req2;
  logic [3:0] tank_en2, fire_gnt2;
  logic [4:0] remaining2;
  logic       level_clear2;
  logic [1:0] sched_state2;

  always #5 clk = ~clk;

  enytank_sched u_dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .game_start(game_start),
    .game_over(game_over), .slot_alive(slot_alive), .fire_req(fire_req),
    .bul_busy(bul_busy), .tank_en(tank_en), .fire_gnt(fire_gnt),
    .remaining(remaining), .level_clear(level_clear), .sched_state(sched_state)
  );

  enytank_sched #(.TOTAL_ENEMIES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .game_start(game_start2),
    .game_over(game_over2), .slot_alive(slot_alive2), .fire_req(fire_req2),
    .bul_busy(bul_busy2), .tank_en(tank_en2), .fire_gnt(fire_gnt2),
    .remaining(remaining2), .level_clear(level_clear2), .sched_state(sched_state2)
  );

  int checks = 0;
  int errors = 0;
  int gnt_cnt = 0;
  logic mon_en = 1'b0;

  logic [3:0]  gnt_q[$];
  logic [8:0]  sp_q[$];
  logic [11:0] st1_q[$];
  logic [11:0] st2_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s unexpected act=%0h", nm, act);
  endtask

  function automatic logic [11:0] rec(input logic [1:0] s, input logic lc,
                                      input logic [3:0] te, input logic [4:0] r);
    return {s, lc, te, r};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1'b1; cyc(1);
      tick = 1'b0; cyc(1);
    end
  endtask

  // Monitor: compare presented outputs against the scoreboard queues.
  logic [3:0]  prev_ten = 4'b0000;
  logic [1:0]  prev_st1 = 2'd0;
  logic [1:0]  prev_st2 = 2'd0;
  logic [11:0] e12;
  logic [8:0]  e9;
  logic [3:0]  e4;
  always @(negedge clk) begin
    if (mon_en) begin
      if (fire_gnt != 4'b0000) begin
        gnt_cnt++;
        if (gnt_q.size() == 0) unexp("grant", 32'(fire_gnt));
        else begin e4 = gnt_q.pop_front(); chk("grant", 32'(fire_gnt), 32'(e4)); end
      end
      if (tank_en != 4'b0000 && prev_ten == 4'b0000) begin
        if (sp_q.size() == 0) unexp("spawn", 32'({tank_en, remaining}));
        else begin e9 = sp_q.pop_front(); chk("spawn", 32'({tank_en, remaining}), 32'(e9)); end
      end
      if (sched_state != prev_st1) begin
        if (st1_q.size() == 0) unexp("state1", 32'(rec(sched_state, level_clear, tank_en, remaining)));
        else begin
          e12 = st1_q.pop_front();
          chk("state1", 32'(rec(sched_state, level_clear, tank_en, remaining)), 32'(e12));
        end
      end
      if (sched_state2 != prev_st2) begin
        if (st2_q.size() == 0) unexp("state2", 32'(rec(sched_state2, level_clear2, tank_en2, remaining2)));
        else begin
          e12 = st2_q.pop_front();
          chk("state2", 32'(rec(sched_state2, level_clear2, tank_en2, remaining2)), 32'(e12));
        end
      end
    end
    prev_ten = tank_en;
    prev_st1 = sched_state;
    prev_st2 = sched_state2;
  end

  int gidx [8] = '{0, 1, 2, 3, 0, 1, 3, 0};

  initial begin
    rst_n = 1'b1; tick = 1'b0; game_start = 1'b0; game_over = 1'b0;
    bul_busy = 1'b0; slot_alive = 4'b0000; fire_req = 4'b0000;
    game_start2 = 1'b0; game_over2 = 1'b0; bul_busy2 = 1'b0;
    slot_alive2 = 4'b0000; fire_req2 = 4'b0000;
    #2 rst_n = 1'b0;
    cyc(2);
    chk("reset_state", 32'({sched_state, level_clear, tank_en, fire_gnt, remaining}), 32'd0);
    rst_n = 1'b1;
    cyc(2);
    mon_en = 1'b1;

    // Start level, first spawn into slot 0, acknowledge.
    st1_q.push_back(rec(ST_RUN, 1'b0, 4'b0000, 5'd20));
    sp_q.push_back({4'b0001, 5'd19});
    game_start = 1'b1; cyc(1); game_start = 1'b0;
    cyc(2);
    chk("first_remaining", 32'(remaining), 32'd19);
    slot_alive = 4'b0001; cyc(1);
    chk("ack_clears_tank_en", 32'(tank_en), 32'd0);

    // Fill remaining slots, one spawn per 8 ticks.
    sp_q.push_back({4'b0010, 5'd18}); tick_n(8); slot_alive = 4'b0011; cyc(1);
    sp_q.push_back({4'b0100, 5'd17}); tick_n(8); slot_alive = 4'b0111; cyc(1);
    sp_q.push_back({4'b1000, 5'd16}); tick_n(8); slot_alive = 4'b1111; cyc(1);
    tick_n(10);
    chk("all_full_no_spawn", 32'(tank_en), 32'd0);
    // Slot 1 drops with gap already expired: immediate spawn.
    sp_q.push_back({4'b0010, 5'd15});
    slot_alive = 4'b1101; cyc(2); slot_alive = 4'b1111; cyc(1);
    // Slot 3 drops mid-gap: spawn only after the 8th tick.
    tick_n(5); slot_alive = 4'b0111; tick_n(2);
    chk("gap_holds_spawn", 32'(tank_en), 32'd0);
    sp_q.push_back({4'b1000, 5'd14});
    tick_n(1); slot_alive = 4'b1111; cyc(1);

    // Round-robin fire grants, each released by a bul_busy 1->0 cycle.
    for (int i = 0; i < 8; i++) begin
      slot_alive = (i >= 5) ? 4'b1011 : 4'b1111;
      gnt_q.push_back(4'b0001 << gidx[i]);
      fire_req = 4'b1111;
      cyc(2);
      bul_busy = 1'b1; cyc(3);
      chk("lock_while_busy", 32'(gnt_cnt), 32'(i + 1));
      bul_busy = 1'b0; cyc(1);
    end
    fire_req = 4'b0000; slot_alive = 4'b1111; cyc(2);

    // Grant with bul_busy never rising: timeout after two ticks.
    gnt_q.push_back(4'b0100);
    fire_req = 4'b0100; cyc(1);
    fire_req = 4'b1111;
    gnt_q.push_back(4'b1000);
    tick_n(1); cyc(3);
    chk("tmo_lock_held", 32'(gnt_cnt), 32'd9);
    tick_n(1); cyc(1);
    fire_req = 4'b0000;
    chk("tmo_release_grant", 32'(gnt_cnt), 32'd10);
    tick_n(2);

    // game_over with a pending spawn into slot 2.
    tick_n(4);
    sp_q.push_back({4'b0100, 5'd13});
    slot_alive = 4'b1011; cyc(2);
    st1_q.push_back(rec(ST_IDLE, 1'b0, 4'b0000, 5'd13));
    game_over = 1'b1; cyc(1); game_over = 1'b0;
    chk("abort_fire_gnt", 32'(fire_gnt), 32'd0);
    cyc(2);

    // Two-enemy level: spawn both, drain, done, restart.
    st2_q.push_back(rec(ST_RUN, 1'b0, 4'b0000, 5'd2));
    game_start2 = 1'b1; cyc(1); game_start2 = 1'b0;
    cyc(2);
    chk("d2_spawn1", 32'({tank_en2, remaining2}), 32'({4'b0001, 5'd1}));
    slot_alive2 = 4'b0001; cyc(1);
    tick_n(8);
    chk("d2_spawn2", 32'({tank_en2, remaining2}), 32'({4'b0010, 5'd0}));
    st2_q.push_back(rec(ST_DRAIN, 1'b0, 4'b0000, 5'd0));
    slot_alive2 = 4'b0011; cyc(3);
    st2_q.push_back(rec(ST_DONE, 1'b1, 4'b0000, 5'd0));
    slot_alive2 = 4'b0000; cyc(2);
    chk("d2_level_clear", 32'(level_clear2), 32'd1);
    st2_q.push_back(rec(ST_RUN, 1'b0, 4'b0000, 5'd2));
    game_start2 = 1'b1; cyc(1); game_start2 = 1'b0;
    cyc(3);

    // Restart main level, then asynchronous reset mid-level.
    st1_q.push_back(rec(ST_RUN, 1'b0, 4'b0000, 5'd20));
    sp_q.push_back({4'b0100, 5'd19});
    game_start = 1'b1; cyc(1); game_start = 1'b0;
    cyc(3);
    st1_q.push_back(rec(ST_IDLE, 1'b0, 4'b0000, 5'd0));
    st2_q.push_back(rec(ST_IDLE, 1'b0, 4'b0000, 5'd0));
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({sched_state, level_clear, tank_en, fire_gnt, remaining}), 32'd0);
    chk("async_reset2", 32'({sched_state2, level_clear2, tank_en2, fire_gnt2, remaining2}), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);

    chk("gnt_q_drained", 32'(gnt_q.size()), 32'd0);
    chk("sp_q_drained", 32'(sp_q.size()), 32'd0);
    chk("st1_q_drained", 32'(st1_q.size()), 32'd0);
    chk("st2_q_drained", 32'(st2_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
